// File: rtl/track_result_fifo.sv
// Tracking-result FIFO: one {I, Q, w_df, seq} entry per tracking_ready rising edge, FWFT read side.
// Optional macro TRACK_FIFO_TIMESTAMP_EN adds a 32-bit cycle stamp per entry on rd_timestamp.
module track_result_fifo #(
  parameter int ACC_W  = 18,
  parameter int WDF_W  = 18,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              flush,
  input  logic              tracking_ready,
  input  logic [ACC_W-1:0]  i_prompt_k,
  input  logic [ACC_W-1:0]  q_prompt_k,
  input  logic [WDF_W-1:0]  w_df_k,
  input  logic              rd_pop,
  output logic              rd_valid,
  output logic [ACC_W-1:0]  rd_i,
  output logic [ACC_W-1:0]  rd_q,
  output logic [WDF_W-1:0]  rd_w_df,
  output logic [7:0]        rd_seq,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic [7:0]        overflow_count,
`ifdef TRACK_FIFO_TIMESTAMP_EN
  output logic [31:0]       rd_timestamp,
`endif
  input  logic              clear_overflow
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int BASE_W = 2 * ACC_W + WDF_W + 8;
`ifdef TRACK_FIFO_TIMESTAMP_EN
  localparam int ENTRY_W = BASE_W + 32;
`else
  localparam int ENTRY_W = BASE_W;
`endif
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LVL_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LVL_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   LVL_FULL = {1'b1, {ADDR_W{1'b0}}};

  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr_r;
  logic [ADDR_W-1:0]  rd_ptr_r;
  logic [ADDR_W:0]    level_r;
  logic [7:0]         seq_r;
  logic               ready_d_r;
  logic               overflow_r;
  logic [7:0]         ovf_cnt_r;

  logic               push_s;
  logic               pop_s;
  logic               full_s;
  logic               wr_en_s;
  logic               drop_s;
  logic [ENTRY_W-1:0] wr_data_s;
  logic [ENTRY_W-1:0] head_s;

`ifdef TRACK_FIFO_TIMESTAMP_EN
  logic [31:0] ts_r;

  // free-running cycle stamp
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ts_r <= 32'd0;
    else       ts_r <= ts_r + 32'd1;
  end
`endif

  // edge detect, full/empty qualification; flush suppresses both write and drop
  always_comb begin
    push_s  = enable & tracking_ready & ~ready_d_r;
    pop_s   = rd_pop & (level_r != LVL_ZERO);
    full_s  = (level_r == LVL_FULL);
    wr_en_s = push_s & ~flush & (~full_s | pop_s);
    drop_s  = push_s & ~flush & full_s & ~pop_s;
  end

  // assemble the entry written on a push cycle
  always_comb begin
    wr_data_s = {ENTRY_W{1'b0}};
    wr_data_s[BASE_W-1:0] = {i_prompt_k, q_prompt_k, w_df_k, seq_r};
`ifdef TRACK_FIFO_TIMESTAMP_EN
    wr_data_s[ENTRY_W-1:BASE_W] = ts_r;
`endif
  end

  // edge-detect history and sequence tag (advances on every push, even dropped or flushed)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_d_r <= 1'b0;
      seq_r     <= 8'd0;
    end else begin
      ready_d_r <= tracking_ready;
      if (push_s) seq_r <= seq_r + 8'd1;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {ADDR_W{1'b0}};
      rd_ptr_r <= {ADDR_W{1'b0}};
      level_r  <= LVL_ZERO;
    end else if (flush) begin
      wr_ptr_r <= {ADDR_W{1'b0}};
      rd_ptr_r <= {ADDR_W{1'b0}};
      level_r  <= LVL_ZERO;
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)   rd_ptr_r <= rd_ptr_r + PTR_ONE;
      if (wr_en_s && !pop_s)      level_r <= level_r + LVL_ONE;
      else if (pop_s && !wr_en_s) level_r <= level_r - LVL_ONE;
      else                        level_r <= level_r;
    end
  end

  // sticky drop flag and saturating counter; a drop beats a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r <= 1'b0;
      ovf_cnt_r  <= 8'd0;
    end else if (clear_overflow) begin
      overflow_r <= drop_s;
      ovf_cnt_r  <= drop_s ? 8'd1 : 8'd0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      if (ovf_cnt_r != 8'd255) ovf_cnt_r <= ovf_cnt_r + 8'd1;
    end
  end

  // storage array; contents need no reset because reads are gated by rd_valid
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_r[wr_ptr_r] <= wr_data_s;
  end

  // FWFT head presentation, forced to zero when empty
  always_comb begin
    head_s   = mem_r[rd_ptr_r];
    rd_valid = (level_r != LVL_ZERO);
    if (rd_valid) begin
      rd_seq  = head_s[7:0];
      rd_w_df = head_s[8 +: WDF_W];
      rd_q    = head_s[8 + WDF_W +: ACC_W];
      rd_i    = head_s[8 + WDF_W + ACC_W +: ACC_W];
    end else begin
      rd_seq  = 8'd0;
      rd_w_df = {WDF_W{1'b0}};
      rd_q    = {ACC_W{1'b0}};
      rd_i    = {ACC_W{1'b0}};
    end
`ifdef TRACK_FIFO_TIMESTAMP_EN
    if (rd_valid) rd_timestamp = head_s[ENTRY_W-1:BASE_W];
    else          rd_timestamp = 32'd0;
`endif
  end

  assign level          = level_r;
  assign overflow       = overflow_r;
  assign overflow_count = ovf_cnt_r;

endmodule

// File: doc/track_result_fifo.md
Name: track_result_fifo

Overview:
- Captures one tracking-loop result per `tracking_ready` rising edge: prompt I, prompt Q and the Doppler word `w_df`.
- Tags each result with a sequence number and stores it in a first-word-fall-through FIFO for the receiver back-end to drain.
- Sits directly downstream of the channel `top` tracking outputs and upstream of the back-end PIO inputs.
- Decouples the once-per-ms tracking burst from the processor's read rate and reports dropped results.

Parameters:
- ACC_W, 18, width of `i_prompt_k` / `q_prompt_k` (signed two's complement, stored verbatim).
- WDF_W, 18, width of `w_df_k` (stored verbatim).
- ADDR_W, 4, FIFO address width; depth = 2**ADDR_W entries (16).

Ports:
- clk  in  1  block clock; also the `top` tracking clock domain.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  capture enable; when low, edges are ignored.
- flush  in  1  synchronous FIFO clear.
- tracking_ready  in  1  level from tracking loop; a result is valid on its rising edge.
- i_prompt_k  in  ACC_W  prompt I accumulation.
- q_prompt_k  in  ACC_W  prompt Q accumulation.
- w_df_k  in  WDF_W  Doppler frequency word.
- rd_pop  in  1  consume head entry.
- rd_valid  out  1  FIFO non-empty; head data valid.
- rd_i  out  ACC_W  head prompt I.
- rd_q  out  ACC_W  head prompt Q.
- rd_w_df  out  WDF_W  head Doppler word.
- rd_seq  out  8  head sequence tag.
- level  out  ADDR_W+1  entries currently stored.
- overflow  out  1  sticky drop flag.
- overflow_count  out  8  saturating count of dropped results.
- clear_overflow  in  1  clears `overflow` and `overflow_count`.

Behaviour:
- Clock and reset:
  - Single clock `clk`.
  - Reset is asynchronous and active-high.
  - On reset: pointers=0, `level`=0, `rd_valid`=0, `rd_i`/`rd_q`/`rd_w_df`/`rd_seq`=0, `overflow`=0, `overflow_count`=0, seq counter=0, `ready_d`=0.
  - Reset asserted mid-operation discards all stored entries.
- Edge detect:
  - `ready_d` is registered `tracking_ready`.
  - push = `enable` & `tracking_ready` & ~`ready_d`, evaluated each cycle.
  - One push per rising edge, regardless of how long the level stays high.
- Capture:
  - On a push cycle, {`i_prompt_k`, `q_prompt_k`, `w_df_k`, seq} is written at the same clock edge.
  - Inputs are sampled in that cycle.
  - seq increments by 1 mod 256 on every push, including dropped pushes, so the host sees gaps.
  - seq does not increment when `enable`=0.
- Read side (FWFT):
  - `rd_*` show mem[rd_ptr] whenever `rd_valid`=1; data outputs are 0 when empty.
  - Empty-FIFO push at edge N: `rd_valid`=1 and data valid from cycle N+1.
  - `rd_pop` with `rd_valid`=1 advances rd_ptr at the clock edge.
  - `rd_pop` while empty is ignored with no side effects.
- Full and simultaneous events:
  - Full (`level`==2**ADDR_W) with push and no pop: entry dropped, `overflow`<=1, `overflow_count`+1, saturating at 255. Stored contents are unchanged.
  - Full with push and pop in the same cycle: pop and push both occur, `level` unchanged, no overflow.
  - Empty with push and pop in the same cycle: pop ignored, push accepted, `level`=1.
  - `clear_overflow` with a simultaneous drop: the drop wins, `overflow`=1, `overflow_count`=1.
- Flush:
  - pointers and `level`<=0, `rd_valid`<=0 on the next cycle.
  - Overrides push and pop in the same cycle; a push in that cycle is discarded, not counted as an overflow, but seq still increments.
  - seq and overflow state are not cleared by flush.
- Pointers:
  - ADDR_W bits, wrap naturally.
  - `level` is a separate ADDR_W+1-bit counter: +1 on push-only, -1 on pop-only.

Optional Feature:
- TRACK_FIFO_TIMESTAMP_EN defined:
  - Adds a 32-bit free-running cycle counter, reset to 0, wrapping at 2**32.
  - Each entry additionally stores the counter value at its push cycle.
  - Output port `rd_timestamp` [31:0] presents the head entry's value, and is 0 when empty.
- Undefined: no counter, no `rd_timestamp` port, and storage width excludes it.

Test Plan:
- Reset, then a single `tracking_ready` rise with I=18'h1_2345, Q=18'h3_FFFE, w_df=18'h0_0A5A -> next cycle `rd_valid`=1, `rd_i`=18'h12345, `rd_q`=18'h3FFFE, `rd_w_df`=18'h00A5A, `rd_seq`=0, `level`=1. Then pop -> `rd_valid`=0, `level`=0.
- `tracking_ready` held high 100 cycles -> exactly one entry, `level`=1.
- 18 edges with no pops -> `level`=16, `overflow`=1, `overflow_count`=2. Draining returns seq 0..15 in order. Next push has `rd_seq`=18.
- At full, push and pop in the same cycle -> `level` stays 16, `overflow_count` unchanged, new tail seq correct. Push and pop on empty -> `level`=1.
- `flush` asserted with a simultaneous push and pop at `level`=5 -> `level`=0, `rd_valid`=0, `overflow_count` unchanged. The following push carries a seq 1 higher than the discarded one.
- `enable`=0 during 3 edges -> no entries, seq unchanged. 300 dropped pushes -> `overflow_count`=255. `clear_overflow` -> 0. Async reset mid-burst -> all outputs 0 immediately.
